// File: rtl/div_writeback_queue_pkg.sv
// Shared types and constants for the divider writeback queue.
package div_writeback_queue_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned DIV_LATENCY = 36;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned TAG_W       = 5;
    localparam int unsigned INFL_W      = $clog2(DIV_LATENCY + 1);
    localparam int unsigned FIFO_CNT_W  = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        DIV_  = 2'd0,
        DIVU_ = 2'd1,
        REM_  = 2'd2,
        REMU_ = 2'd3
    } div_ops_e;

    // One captured divider result waiting for writeback
    typedef struct packed {
        logic [XLEN-1:0]  data;
        logic             div_by_zero;
        logic [TAG_W-1:0] tag;
        div_ops_e         op;
    } div_wb_entry_s;

    // Token travelling alongside the divider pipeline
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        div_ops_e         op;
    } div_token_s;

    localparam int unsigned ENTRY_W = $bits(div_wb_entry_s);

endpackage

// File: rtl/div_writeback_queue_if.sv
// Issue and writeback handshake bundle of the divider writeback queue.
interface div_writeback_queue_if;
    import div_writeback_queue_pkg::*;

    logic             issue_valid_i;
    logic             issue_ready_o;
    logic [TAG_W-1:0] issue_tag_i;
    div_ops_e         issue_op_i;

    logic             wb_valid_o;
    logic             wb_ready_i;
    logic [XLEN-1:0]  wb_data_o;
    logic [TAG_W-1:0] wb_tag_o;
    div_ops_e         wb_op_o;
    logic             wb_div_by_zero_o;

    // Upstream issuer plus writeback arbiter side
    modport master (
        output issue_valid_i, issue_tag_i, issue_op_i, wb_ready_i,
        input  issue_ready_o, wb_valid_o, wb_data_o, wb_tag_o, wb_op_o, wb_div_by_zero_o
    );

    // Queue side
    modport slave (
        input  issue_valid_i, issue_tag_i, issue_op_i, wb_ready_i,
        output issue_ready_o, wb_valid_o, wb_data_o, wb_tag_o, wb_op_o, wb_div_by_zero_o
    );

endinterface

// File: rtl/div_writeback_queue_sync_fifo_ptr.sv
// Generic pointer-based synchronous FIFO with occupancy count and flush.
module sync_fifo_ptr #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Occupancy: simultaneous push and pop leaves the count unchanged
    always_comb begin
        count_d = count_q;
        if (do_push & ~do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop & ~do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Storage and pointers; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/div_writeback_queue.sv
// Tracks divides through a latency-matched token line and queues their results for writeback.
module div_writeback_queue
    import div_writeback_queue_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clk_en_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   result_i,
    input  logic              div_by_zero_i,
    div_writeback_queue_if.slave q_if,
    output logic [INFL_W-1:0] inflight_o
);

    localparam int unsigned SUM_W = (INFL_W > FIFO_CNT_W ? INFL_W : FIFO_CNT_W) + 1;

    div_token_s          line_q [DIV_LATENCY];
    logic [INFL_W-1:0]   inflight_q, inflight_d;
    logic                issue_ready;
    logic                issue_fire;
    logic                capture;
    div_wb_entry_s       cap_entry;
    div_wb_entry_s       head_entry;
    logic [ENTRY_W-1:0]  head_raw;
    logic [FIFO_CNT_W-1:0] fifo_count;
    logic                fifo_full, fifo_empty;
    logic                wb_pop;

    // Credits cover both tokens in flight and entries queued, so a capture always finds room
    assign issue_ready = (SUM_W'(inflight_q) + SUM_W'(fifo_count)) < SUM_W'(FIFO_DEPTH);
    assign issue_fire  = q_if.issue_valid_i & issue_ready & clk_en_i;
    assign capture     = line_q[DIV_LATENCY-1].valid & clk_en_i;

    assign cap_entry = '{data:        result_i,
                         div_by_zero: div_by_zero_i,
                         tag:         line_q[DIV_LATENCY-1].tag,
                         op:          line_q[DIV_LATENCY-1].op};

    // Token delay line; frozen while the divider is clock-gated, cleared on flush
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int unsigned i = 0; i < DIV_LATENCY; i++) begin
                line_q[i] <= '0;
            end
        end else if (flush_i) begin
            for (int unsigned i = 0; i < DIV_LATENCY; i++) begin
                line_q[i].valid <= 1'b0;
            end
        end else if (clk_en_i) begin
            line_q[0] <= '{valid: issue_fire, tag: q_if.issue_tag_i, op: q_if.issue_op_i};
            for (int unsigned i = 1; i < DIV_LATENCY; i++) begin
                line_q[i] <= line_q[i-1];
            end
        end
    end

    // In-flight token count
    always_comb begin
        inflight_d = inflight_q;
        if (flush_i) begin
            inflight_d = '0;
        end else if (issue_fire & ~capture) begin
            inflight_d = inflight_q + INFL_W'(1);
        end else if (capture & ~issue_fire) begin
            inflight_d = inflight_q - INFL_W'(1);
        end
    end

    // In-flight count register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign wb_pop = ~fifo_empty & q_if.wb_ready_i;

    sync_fifo_ptr #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (capture & ~fifo_full),
        .wdata_i (cap_entry),
        .pop_i   (wb_pop),
        .rdata_o (head_raw),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Head entry is presented directly; payload reads as zero while empty
    assign head_entry = fifo_empty ? '0 : div_wb_entry_s'(head_raw);

    assign q_if.issue_ready_o    = issue_ready;
    assign q_if.wb_valid_o       = ~fifo_empty;
    assign q_if.wb_data_o        = head_entry.data;
    assign q_if.wb_tag_o         = head_entry.tag;
    assign q_if.wb_op_o          = head_entry.op;
    assign q_if.wb_div_by_zero_o = head_entry.div_by_zero;
    assign inflight_o            = inflight_q;

endmodule

// File: tb/tb_div_writeback_queue.sv
// Randomised and directed scoreboard bench for div_writeback_queue.
module tb_div_writeback_queue;
    import div_writeback_queue_pkg::*;

    typedef struct {
        logic [XLEN-1:0]  data;
        logic             dbz;
        logic [TAG_W-1:0] tag;
        div_ops_e         op;
        int               rem;
    } tok_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clk_en;
    logic              flush;
    logic [XLEN-1:0]   result;
    logic              dbz;
    logic [INFL_W-1:0] inflight;

    // Result the divider will produce for the operation currently being issued
    logic [XLEN-1:0]   s_data;
    logic              s_dbz;

    int vectors     = 0;
    int miscompares = 0;

    tok_t pend_q [$];
    tok_t cap_q  [$];
    tok_t t;
    int   occ;

    div_writeback_queue_if q_if();

    div_writeback_queue dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .clk_en_i      (clk_en),
        .flush_i       (flush),
        .result_i      (result),
        .div_by_zero_i (dbz),
        .q_if          (q_if),
        .inflight_o    (inflight)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: each issued divide completes DIV_LATENCY enabled edges later
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q.delete();
            cap_q.delete();
        end else begin
            occ = pend_q.size() + cap_q.size();
            if (flush) begin
                pend_q.delete();
                cap_q.delete();
            end else begin
                if (cap_q.size() > 0 && q_if.wb_ready_i) void'(cap_q.pop_front());
                if (clk_en) begin
                    foreach (pend_q[i]) pend_q[i].rem--;
                    if (pend_q.size() > 0 && pend_q[0].rem == 0) cap_q.push_back(pend_q.pop_front());
                    if (q_if.issue_valid_i && occ < FIFO_DEPTH) begin
                        t.data = s_data;
                        t.dbz  = s_dbz;
                        t.tag  = q_if.issue_tag_i;
                        t.op   = q_if.issue_op_i;
                        t.rem  = DIV_LATENCY;
                        pend_q.push_back(t);
                    end
                end
            end
        end
    end

    // Divider stand-in: the oldest operation's result appears in its final cycle, noise otherwise
    always @(posedge clk) begin
        #1;
        if (pend_q.size() > 0 && pend_q[0].rem == 1) begin
            result = pend_q[0].data;
            dbz    = pend_q[0].dbz;
        end else begin
            result = $urandom;
            dbz    = 1'($urandom);
        end
    end

    // Monitor: compare DUT against the model every cycle, away from the clock edge
    always @(negedge clk) begin
        if (rst_n) begin
            chk("wb_valid", 32'(q_if.wb_valid_o), 32'(cap_q.size() != 0));
            chk("issue_ready", 32'(q_if.issue_ready_o),
                32'((pend_q.size() + cap_q.size()) < FIFO_DEPTH));
            chk("inflight", 32'(inflight), 32'(pend_q.size()));
            if (q_if.wb_valid_o && cap_q.size() > 0) begin
                chk("wb_data", q_if.wb_data_o, cap_q[0].data);
                chk("wb_tag", 32'(q_if.wb_tag_o), 32'(cap_q[0].tag));
                chk("wb_op", 32'(q_if.wb_op_o), 32'(cap_q[0].op));
                chk("wb_dbz", 32'(q_if.wb_div_by_zero_o), 32'(cap_q[0].dbz));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_issue(input logic v, input logic [TAG_W-1:0] tag, input div_ops_e op,
                             input logic [XLEN-1:0] data, input logic z);
        q_if.issue_valid_i = v;
        q_if.issue_tag_i   = tag;
        q_if.issue_op_i    = op;
        s_data             = data;
        s_dbz              = z;
    endtask

    // Count negedges until wb_valid_o rises, bounded
    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!q_if.wb_valid_o && n < 100);
        chk("wb_valid_timeout", 32'(q_if.wb_valid_o), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1);
    end

    initial begin
        int n;
        rst_n  = 1'b0;
        clk_en = 1'b1;
        flush  = 1'b0;
        result = '0;
        dbz    = 1'b0;
        q_if.wb_ready_i = 1'b0;
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        #1;
        chk("rst_wb_valid", 32'(q_if.wb_valid_o), 32'd0);
        chk("rst_inflight", 32'(inflight), 32'd0);
        chk("rst_wb_data", q_if.wb_data_o, 32'd0);
        chk("rst_wb_tag", 32'(q_if.wb_tag_o), 32'd0);
        chk("rst_wb_dbz", 32'(q_if.wb_div_by_zero_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_issue_ready", 32'(q_if.issue_ready_o), 32'd1);

        // Single DIVU_ with nominal latency
        tick();
        set_issue(1'b1, 5'd7, DIVU_, 32'h0000_0005, 1'b0);
        tick();
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        wait_valid(n);
        chk("lat_nominal", 32'(n), 32'd37);
        chk("single_data", q_if.wb_data_o, 32'h5);
        chk("single_tag", 32'(q_if.wb_tag_o), 32'd7);
        tick();
        q_if.wb_ready_i = 1'b1;
        tick();
        q_if.wb_ready_i = 1'b0;
        @(negedge clk);
        chk("single_popped", 32'(q_if.wb_valid_o), 32'd0);
        chk("single_ready", 32'(q_if.issue_ready_o), 32'd1);

        // Four back-to-back issues exhaust credits
        for (int i = 1; i <= 4; i++) begin
            tick();
            set_issue(1'b1, TAG_W'(i), div_ops_e'(2'(i)), $urandom, 1'($urandom));
        end
        tick();
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        @(negedge clk);
        chk("credits_out", 32'(q_if.issue_ready_o), 32'd0);
        repeat (40) tick();
        @(negedge clk);
        chk("full_hold_ready", 32'(q_if.issue_ready_o), 32'd0);
        chk("full_head_tag", 32'(q_if.wb_tag_o), 32'd1);
        tick();
        q_if.wb_ready_i = 1'b1;
        tick();
        q_if.wb_ready_i = 1'b0;
        @(negedge clk);
        chk("credit_return", 32'(q_if.issue_ready_o), 32'd1);
        chk("second_head_tag", 32'(q_if.wb_tag_o), 32'd2);
        tick();
        q_if.wb_ready_i = 1'b1;
        repeat (4) tick();
        q_if.wb_ready_i = 1'b0;

        // Clock-enable stall of 10 cycles delays capture by 10
        tick();
        set_issue(1'b1, 5'd12, DIV_, $urandom, 1'b0);
        tick();
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        repeat (14) tick();
        clk_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall_inflight", 32'(inflight), 32'd1);
            tick();
        end
        clk_en = 1'b1;
        wait_valid(n);
        chk("lat_stall", 32'(24 + n), 32'd47);
        tick();
        q_if.wb_ready_i = 1'b1;
        tick();
        q_if.wb_ready_i = 1'b0;

        // REM_ with divide-by-zero flag
        tick();
        set_issue(1'b1, 5'd20, REM_, 32'hDEAD_BEEF, 1'b1);
        tick();
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        wait_valid(n);
        chk("rem_dbz", 32'(q_if.wb_div_by_zero_o), 32'd1);
        chk("rem_op", 32'(q_if.wb_op_o), 32'(REM_));
        tick();
        q_if.wb_ready_i = 1'b1;
        tick();
        q_if.wb_ready_i = 1'b0;

        // Flush with one queued and two in flight
        tick();
        set_issue(1'b1, 5'd10, DIVU_, $urandom, 1'b0);
        tick();
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        wait_valid(n);
        tick();
        set_issue(1'b1, 5'd11, DIV_, $urandom, 1'b0);
        tick();
        set_issue(1'b1, 5'd13, REMU_, $urandom, 1'b0);
        tick();
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(q_if.wb_valid_o), 32'd0);
        chk("flush_inflight", 32'(inflight), 32'd0);
        chk("flush_ready", 32'(q_if.issue_ready_o), 32'd1);
        repeat (45) tick();
        @(negedge clk);
        chk("flush_no_capture", 32'(q_if.wb_valid_o), 32'd0);

        // Asynchronous reset mid-flight
        tick();
        set_issue(1'b1, 5'd3, DIV_, $urandom, 1'b0);
        tick();
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        wait_valid(n);
        tick();
        set_issue(1'b1, 5'd4, DIV_, $urandom, 1'b0);
        tick();
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(q_if.wb_valid_o), 32'd0);
        chk("arst_inflight", 32'(inflight), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        set_issue(1'b1, 5'd9, REMU_, 32'h1234_5678, 1'b0);
        tick();
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        wait_valid(n);
        chk("post_rst_lat", 32'(n), 32'd37);
        chk("post_rst_data", q_if.wb_data_o, 32'h1234_5678);
        tick();
        q_if.wb_ready_i = 1'b1;
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            clk_en          = ($urandom_range(0, 99) < 85);
            flush           = ($urandom_range(0, 99) < 1);
            q_if.wb_ready_i = ($urandom_range(0, 99) < 50);
            set_issue(($urandom_range(0, 99) < 60), TAG_W'($urandom),
                      div_ops_e'(2'($urandom)), $urandom, 1'($urandom));
            tick();
        end

        // Drain
        clk_en          = 1'b1;
        flush           = 1'b0;
        q_if.wb_ready_i = 1'b1;
        set_issue(1'b0, '0, DIV_, '0, 1'b0);
        repeat (60) tick();
        @(negedge clk);
        chk("drain_empty", 32'(q_if.wb_valid_o), 32'd0);
        chk("drain_inflight", 32'(inflight), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
